// File: rtl/mem_wb_arbiter_pkg.sv
// Shared types and constants for the I/D memory arbiter.
package mem_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_ERR   = 2'd3
    } arb_state_t;

    localparam logic OWNER_I    = 1'b0;
    localparam logic OWNER_D    = 1'b1;
    localparam int   MEM_AW_DEF = 15;

    // Any address bit at or above the decoded window marks the access as out of range.
    function automatic logic addr_out_of_range(input logic [31:0] adr, input int unsigned aw);
        return (adr >> aw) != 32'd0;
    endfunction

endpackage

// File: rtl/mem_wb_arbiter_if.sv
// Bus bundle between CPU fetch/load-store masters, the arbiter and the shared memory.
interface mem_wb_arbiter_if;
    logic [31:0] i_adr_i;
    logic        i_stb_i;
    logic [31:0] i_dat_o;
    logic        i_ack_o;
    logic        i_err_o;
    logic [31:0] d_adr_i;
    logic [31:0] d_dat_i;
    logic        d_we_i;
    logic        d_stb_i;
    logic [31:0] d_dat_o;
    logic        d_ack_o;
    logic        d_err_o;
    logic [31:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic        s_we_o;
    logic        s_stb_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic        owner_o;

    // Arbiter side of the bundle.
    modport slave (
        input  i_adr_i, i_stb_i, d_adr_i, d_dat_i, d_we_i, d_stb_i, s_dat_i, s_ack_i,
        output i_dat_o, i_ack_o, i_err_o, d_dat_o, d_ack_o, d_err_o,
               s_adr_o, s_dat_o, s_we_o, s_stb_o, owner_o
    );

    // CPU masters and memory side of the bundle.
    modport master (
        output i_adr_i, i_stb_i, d_adr_i, d_dat_i, d_we_i, d_stb_i, s_dat_i, s_ack_i,
        input  i_dat_o, i_ack_o, i_err_o, d_dat_o, d_ack_o, d_err_o,
               s_adr_o, s_dat_o, s_we_o, s_stb_o, owner_o
    );
endinterface

// File: rtl/mem_wb_arbiter_arb_rr2.sv
// Two-requester arbiter: bit 0 = fetch (I), bit 1 = load/store (D).
// gnt is only meaningful while some req bit is set.
module arb_rr2
    import mem_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       fixed_prio,
    input  logic       grant_en,
    output logic       gnt
);
    logic rr_last_q;
    logic rr_last_d;

    // Winner selection; on a conflict round-robin favours whoever did not win last.
    always_comb begin
        gnt       = OWNER_I;
        rr_last_d = rr_last_q;
        if (fixed_prio) begin
            gnt = req[1] ? OWNER_D : OWNER_I;
        end else if (&req) begin
            gnt = ~rr_last_q;
        end else begin
            gnt = req[1] ? OWNER_D : OWNER_I;
        end
        if (grant_en && (|req)) begin
            rr_last_d = gnt;
        end
    end

    // Last-winner history, starts as I so the first conflict goes to D.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_last_q <= OWNER_I;
        else     rr_last_q <= rr_last_d;
    end
endmodule

// File: rtl/mem_wb_arbiter.sv
// Shares one registered-read memory between CPU fetch and load/store masters.
// One transaction in flight: IDLE -> ISSUE -> RESP -> IDLE, or IDLE -> ERR -> IDLE.
module mem_wb_arbiter
    import mem_wb_arbiter_pkg::*;
#(
    parameter int MEM_AW     = MEM_AW_DEF,
    parameter int FIXED_PRIO = 0
) (
    input logic              clk,
    input logic              rst,
    mem_wb_arbiter_if.slave  bus
);
    localparam logic FP = (FIXED_PRIO != 0);

    arb_state_t  state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        we_q, we_d;
    logic        stb_q, stb_d;
    logic [31:0] i_dat_q, i_dat_d;
    logic [31:0] d_dat_q, d_dat_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        i_err_q, i_err_d;
    logic        d_err_q, d_err_d;

    logic [1:0]  req;
    logic        gnt;
    logic        grant_en;
    logic [31:0] win_adr;

    assign req      = {bus.d_stb_i, bus.i_stb_i};
    assign grant_en = (state_q == ST_IDLE);
    assign win_adr  = (gnt == OWNER_D) ? bus.d_adr_i : bus.i_adr_i;

    arb_rr2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .fixed_prio (FP),
        .grant_en   (grant_en),
        .gnt        (gnt)
    );

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        stb_d   = stb_q;
        i_dat_d = i_dat_q;
        d_dat_d = d_dat_q;
        i_ack_d = 1'b0;
        d_ack_d = 1'b0;
        i_err_d = 1'b0;
        d_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    owner_d = gnt;
                    adr_d   = win_adr;
                    if (gnt == OWNER_D) wdat_d = bus.d_dat_i;
                    if (addr_out_of_range(win_adr, MEM_AW)) begin
                        state_d = ST_ERR;
                        we_d    = 1'b0;
                    end else begin
                        state_d = ST_ISSUE;
                        stb_d   = 1'b1;
                        we_d    = (gnt == OWNER_D) && bus.d_we_i;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.s_ack_i) begin
                    stb_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Memory data is valid this cycle; a master that withdrew gets no ack.
                if (owner_q == OWNER_D) begin
                    d_ack_d = bus.d_stb_i;
                    if (!we_q) d_dat_d = bus.s_dat_i;
                end else begin
                    i_ack_d = bus.i_stb_i;
                    i_dat_d = bus.s_dat_i;
                end
                we_d    = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (owner_q == OWNER_D) d_err_d = bus.d_stb_i;
                else                    i_err_d = bus.i_stb_i;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset also withdraws any in-flight strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_I;
            adr_q   <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            i_dat_q <= '0;
            d_dat_q <= '0;
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            i_err_q <= 1'b0;
            d_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            i_dat_q <= i_dat_d;
            d_dat_q <= d_dat_d;
            i_ack_q <= i_ack_d;
            d_ack_q <= d_ack_d;
            i_err_q <= i_err_d;
            d_err_q <= d_err_d;
        end
    end

    assign bus.s_adr_o = adr_q;
    assign bus.s_dat_o = wdat_q;
    assign bus.s_we_o  = we_q;
    assign bus.s_stb_o = stb_q;
    assign bus.i_dat_o = i_dat_q;
    assign bus.i_ack_o = i_ack_q;
    assign bus.i_err_o = i_err_q;
    assign bus.d_dat_o = d_dat_q;
    assign bus.d_ack_o = d_ack_q;
    assign bus.d_err_o = d_err_q;
    assign bus.owner_o = owner_q;
endmodule

// File: tb/tb_mem_wb_arbiter.sv
// Directed bench: round-robin instance with a wait-state memory, plus a fixed-priority instance.
module tb_mem_wb_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_wb_arbiter_if b0 ();
    mem_wb_arbiter_if b1 ();

    mem_wb_arbiter #(.MEM_AW(15), .FIXED_PRIO(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    mem_wb_arbiter #(.MEM_AW(15), .FIXED_PRIO(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    // Memory model for dut0: programmable wait states, registered read data.
    logic [31:0] mem0 [0:8191];
    int          wait0;
    int          wcnt0;
    logic [31:0] rd0;
    logic        pl_we;
    logic [12:0] pl_idx;
    logic [31:0] pl_dat;

    assign b0.s_ack_i = b0.s_stb_o && (wcnt0 == wait0);
    assign b0.s_dat_i = rd0;

    always @(posedge clk or posedge rst) begin
        if (rst)                            wcnt0 <= 0;
        else if (b0.s_stb_o && !b0.s_ack_i) wcnt0 <= wcnt0 + 1;
        else                                wcnt0 <= 0;
    end

    always @(posedge clk) begin
        if (pl_we) mem0[pl_idx] <= pl_dat;
        else if (b0.s_stb_o && b0.s_ack_i) begin
            if (b0.s_we_o) mem0[b0.s_adr_o[14:2]] <= b0.s_dat_o;
            else           rd0 <= mem0[b0.s_adr_o[14:2]];
        end
    end

    // Memory for dut1: zero-wait, data not examined.
    assign b1.s_ack_i = b1.s_stb_o;
    assign b1.s_dat_i = 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction on dut0 from I (is_d=0) or D (is_d=1), bounded to 20 cycles.
    task automatic run_x(input bit is_d, input logic [31:0] adr, input logic [31:0] wd, input bit we,
                         output bit ack, output bit err, output logic [31:0] rdat,
                         output int cyc, output int stb_cyc, output bit we_seen, output bit other);
        ack = 0; err = 0; rdat = '0; cyc = 0; stb_cyc = 0; we_seen = 0; other = 0;
        if (is_d) begin
            b0.d_adr_i = adr; b0.d_dat_i = wd; b0.d_we_i = we; b0.d_stb_i = 1'b1;
        end else begin
            b0.i_adr_i = adr; b0.i_stb_i = 1'b1;
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            cyc++;
            if (b0.s_stb_o) stb_cyc++;
            if (b0.s_we_o) we_seen = 1;
            if (is_d ? (b0.i_ack_o | b0.i_err_o) : (b0.d_ack_o | b0.d_err_o)) other = 1;
            ack = is_d ? b0.d_ack_o : b0.i_ack_o;
            err = is_d ? b0.d_err_o : b0.i_err_o;
            if (ack || err) begin
                rdat = is_d ? b0.d_dat_o : b0.i_dat_o;
                break;
            end
        end
        b0.d_stb_i = 1'b0; b0.d_we_i = 1'b0; b0.i_stb_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ack, err, we_seen, other, flag;
        logic [31:0] rdat;
        int          cyc, stb_cyc, n, nd, ni;
        bit          got [0:5];
        bit          own [0:5];
        logic [31:0] dat [0:5];
        bit          exp_rr [0:5];
        bit          exp_fp [0:5];
        exp_rr = '{1, 0, 1, 0, 1, 0};
        exp_fp = '{1, 1, 1, 0, 0, 0};

        rst = 1'b1;
        wait0 = 0; pl_we = 1'b0; pl_idx = '0; pl_dat = '0;
        b0.i_adr_i = '0; b0.i_stb_i = 0; b0.d_adr_i = '0; b0.d_dat_i = '0; b0.d_we_i = 0; b0.d_stb_i = 0;
        b1.i_adr_i = '0; b1.i_stb_i = 0; b1.d_adr_i = '0; b1.d_dat_i = '0; b1.d_we_i = 0; b1.d_stb_i = 0;
        repeat (2) tick();
        pl_we = 1'b1;
        pl_idx = 13'd4;  pl_dat = 32'hDEADBEEF; tick();
        pl_idx = 13'd8;  pl_dat = 32'h0;        tick();
        pl_idx = 13'd16; pl_dat = 32'h0;        tick();
        pl_we = 1'b0;

        chk("rst_s_stb", 32'(b0.s_stb_o), 0);
        chk("rst_s_we", 32'(b0.s_we_o), 0);
        chk("rst_owner", 32'(b0.owner_o), 0);
        chk("rst_acks", 32'({b0.i_ack_o, b0.d_ack_o, b0.i_err_o, b0.d_err_o}), 0);
        chk("rst_s_adr", b0.s_adr_o, 0);
        chk("rst_i_dat", b0.i_dat_o, 0);
        chk("rst_d_dat", b0.d_dat_o, 0);
        chk("rst_b1_stb", 32'(b1.s_stb_o), 0);

        rst = 1'b0;
        tick();

        run_x(0, 32'h10, 0, 0, ack, err, rdat, cyc, stb_cyc, we_seen, other);
        chk("fetch_ack", 32'(ack), 1);
        chk("fetch_err", 32'(err), 0);
        chk("fetch_lat", cyc, 3);
        chk("fetch_dat", rdat, 32'hDEADBEEF);
        chk("fetch_we", 32'(we_seen), 0);
        chk("fetch_stbcyc", stb_cyc, 1);
        chk("fetch_other", 32'(other), 0);
        tick();
        chk("fetch_ack_pulse", 32'(b0.i_ack_o), 0);
        chk("fetch_no_reissue", 32'(b0.s_stb_o), 0);

        run_x(1, 32'h20, 32'h12345678, 1, ack, err, rdat, cyc, stb_cyc, we_seen, other);
        chk("store_ack", 32'(ack), 1);
        chk("store_lat", cyc, 3);
        chk("store_we", 32'(we_seen), 1);
        chk("store_owner", 32'(b0.owner_o), 1);
        chk("store_dat_unch", rdat, 0);

        run_x(1, 32'h20, 0, 0, ack, err, rdat, cyc, stb_cyc, we_seen, other);
        chk("load_ack", 32'(ack), 1);
        chk("load_dat", rdat, 32'h12345678);
        chk("load_mem8", mem0[8], 32'h12345678);

        run_x(1, 32'h0000_8000, 0, 0, ack, err, rdat, cyc, stb_cyc, we_seen, other);
        chk("oor_err", 32'(err), 1);
        chk("oor_ack", 32'(ack), 0);
        chk("oor_stb", stb_cyc, 0);
        chk("oor_lat", cyc, 2);
        chk("oor_owner", 32'(b0.owner_o), 1);
        chk("oor_dat_unch", rdat, 32'h12345678);
        tick();
        chk("oor_err_pulse", 32'(b0.d_err_o), 0);

        run_x(1, 32'h20, 0, 0, ack, err, rdat, cyc, stb_cyc, we_seen, other);
        chk("after_oor_ack", 32'(ack), 1);
        chk("after_oor_dat", rdat, 32'h12345678);

        run_x(0, 32'h7FFC, 0, 0, ack, err, rdat, cyc, stb_cyc, we_seen, other);
        chk("top_addr_ack", 32'(ack), 1);
        chk("top_addr_err", 32'(err), 0);

        wait0 = 2;
        run_x(0, 32'h10, 0, 0, ack, err, rdat, cyc, stb_cyc, we_seen, other);
        chk("ws_ack", 32'(ack), 1);
        chk("ws_lat", cyc, 5);
        chk("ws_stbcyc", stb_cyc, 3);
        chk("ws_dat", rdat, 32'hDEADBEEF);

        b0.d_adr_i = 32'h40; b0.d_dat_i = 32'hCAFEF00D; b0.d_we_i = 1'b1; b0.d_stb_i = 1'b1;
        tick();
        chk("rstiss_stb", 32'(b0.s_stb_o), 1);
        chk("rstiss_we", 32'(b0.s_we_o), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstiss_stb0", 32'(b0.s_stb_o), 0);
        chk("rstiss_we0", 32'(b0.s_we_o), 0);
        chk("rstiss_adr0", b0.s_adr_o, 0);
        chk("rstiss_sdat0", b0.s_dat_o, 0);
        chk("rstiss_owner0", 32'(b0.owner_o), 0);
        chk("rstiss_ack0", 32'(b0.d_ack_o), 0);
        b0.d_stb_i = 1'b0; b0.d_we_i = 1'b0;
        tick();
        tick();
        chk("rstiss_noack", 32'(b0.d_ack_o), 0);
        rst = 1'b0;
        wait0 = 0;
        chk("rstiss_mem16", mem0[16], 0);
        run_x(0, 32'h10, 0, 0, ack, err, rdat, cyc, stb_cyc, we_seen, other);
        chk("post_rst_ack", 32'(ack), 1);
        chk("post_rst_lat", cyc, 3);
        chk("post_rst_dat", rdat, 32'hDEADBEEF);

        // Round robin: rr_last is I after the last fetch, so D goes first.
        b0.i_adr_i = 32'h10; b0.i_stb_i = 1'b1;
        b0.d_adr_i = 32'h20; b0.d_we_i = 1'b0; b0.d_stb_i = 1'b1;
        n = 0; flag = 0;
        for (int k = 0; k < 60 && n < 6; k++) begin
            tick();
            if (b0.i_ack_o && b0.d_ack_o) flag = 1;
            if (b0.i_ack_o || b0.d_ack_o) begin
                got[n] = b0.d_ack_o;
                own[n] = b0.owner_o;
                dat[n] = b0.d_ack_o ? b0.d_dat_o : b0.i_dat_o;
                n++;
            end
        end
        b0.i_stb_i = 1'b0; b0.d_stb_i = 1'b0;
        chk("rr_count", n, 6);
        chk("rr_dual_ack", 32'(flag), 0);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("rr_who_%0d", k), 32'(got[k]), 32'(exp_rr[k]));
            chk($sformatf("rr_owner_%0d", k), 32'(own[k]), 32'(exp_rr[k]));
            chk($sformatf("rr_dat_%0d", k), dat[k], exp_rr[k] ? 32'h12345678 : 32'hDEADBEEF);
        end

        run_x(0, 32'h10, 0, 0, ack, err, rdat, cyc, stb_cyc, we_seen, other);
        b0.i_adr_i = 32'h10; b0.i_stb_i = 1'b1;
        tick();
        chk("drop_stb_issued", 32'(b0.s_stb_o), 1);
        b0.i_stb_i = 1'b0;
        flag = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (b0.i_ack_o || b0.i_err_o) flag = 1;
        end
        chk("drop_no_ack", 32'(flag), 0);

        // Fixed priority instance: D wins every conflict until it withdraws.
        b1.i_adr_i = 32'h10; b1.i_stb_i = 1'b1;
        b1.d_adr_i = 32'h20; b1.d_we_i = 1'b0; b1.d_stb_i = 1'b1;
        n = 0; nd = 0; ni = 0;
        for (int k = 0; k < 60 && n < 6; k++) begin
            tick();
            if (b1.i_ack_o || b1.d_ack_o) begin
                got[n] = b1.d_ack_o;
                own[n] = b1.owner_o;
                n++;
                if (b1.d_ack_o) nd++;
                if (b1.i_ack_o) ni++;
                if (nd == 3) b1.d_stb_i = 1'b0;
                if (ni == 3) b1.i_stb_i = 1'b0;
            end
        end
        b1.i_stb_i = 1'b0; b1.d_stb_i = 1'b0;
        chk("fp_count", n, 6);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("fp_who_%0d", k), 32'(got[k]), 32'(exp_fp[k]));
            chk($sformatf("fp_owner_%0d", k), 32'(own[k]), 32'(exp_fp[k]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
